// File: rtl/sim_console_monitor.sv
`default_nettype none
// ============================================================================
// sim_console_monitor: console line capture into ping-pong banks, valid/ready
// line drain and run watchdog. Optional CONSOLE_TIMESTAMP_EN adds out_stamp.
// Rev 1.0
// ============================================================================
module sim_console_monitor #(
  parameter int LINE_MAX       = 256,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 32,
  parameter int DROP_CR        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             sim_done,
  input  logic [31:0]      sim_exit_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      exit_code,
  output logic [15:0]      drop_count,
  output logic [CNT_W-1:0] cycle_count
`ifdef CONSOLE_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0] out_stamp
`endif
);

  localparam int               LEN_W    = $clog2(LINE_MAX);
  localparam logic [LEN_W-1:0] CHAR_MAX = LEN_W'(LINE_MAX - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LF       = 8'h0A;
  localparam logic [7:0]       CR       = 8'h0D;

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_FLUSH_DONE = 3'd1,
    S_FLUSH_TO   = 3'd2,
    S_DONE       = 3'd3,
    S_TIMEOUT    = 3'd4
  } run_t;

  run_t             run_state;
  logic             cap_bank;
  logic             rd_bank;
  logic [1:0]       bank_full;
  logic [LEN_W-1:0] bank_len [2];
  logic [LEN_W-1:0] cap_cnt;
  logic [LEN_W-1:0] rd_idx;
  logic [7:0]       mem [2][LINE_MAX];
`ifdef CONSOLE_TIMESTAMP_EN
  logic [CNT_W-1:0] stamp [2];
`endif

  logic             is_run, cap_free, go_done, go_to, flush;
  logic             lf_close, store, drop, close, bypass;
  logic [LEN_W-1:0] cnt_next, nlen, nidx;
  logic [1:0]       close_vec, free_vec;
  logic             fire, take, mid, nb;
  logic [7:0]       first_byte;

  always_comb begin
    is_run   = (run_state == S_RUN);
    cap_free = !bank_full[cap_bank];
    go_done  = is_run && sim_done;
    go_to    = is_run && !sim_done && (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);
    flush    = go_done || go_to;
    lf_close = 1'b0;
    store    = 1'b0;
    drop     = 1'b0;
    if (is_run && in_valid) begin
      if (!cap_free)
        drop = 1'b1;
      else if (in_data == LF)
        lf_close = 1'b1;
      else if (!(in_data == CR && DROP_CR != 0)) begin
        if (cap_cnt < CHAR_MAX) store = 1'b1;
        else                    drop  = 1'b1;
      end
    end
    cnt_next  = cap_cnt + LEN_W'(store);
    close     = lf_close || (flush && cap_free && cnt_next != '0);
    close_vec = close ? (2'b01 << cap_bank) : 2'b00;

    // out_valid doubles as the drain state: low = IDLE, high = DRAIN
    fire     = out_valid && out_ready;
    take     = !out_valid || fire;
    mid      = out_valid && !out_last;
    free_vec = (fire && out_last) ? (2'b01 << rd_bank) : 2'b00;
    nb       = (out_valid && out_last) ? ~rd_bank : rd_bank;
    nlen     = close_vec[nb] ? cnt_next : bank_len[nb];
    nidx     = rd_idx + 1'b1;
    // a line closing this edge may still have its first byte in flight
    bypass     = close_vec[nb] && (cap_cnt == '0);
    first_byte = bypass ? in_data : mem[nb][0];
  end

  always_ff @(posedge clk) begin
    if (store) mem[cap_bank][cap_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_state   <= S_RUN;
      cap_bank    <= 1'b0;
      rd_bank     <= 1'b0;
      bank_full   <= 2'b00;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      cap_cnt     <= '0;
      rd_idx      <= '0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= 32'h0;
      drop_count  <= 16'h0;
      cycle_count <= '0;
`ifdef CONSOLE_TIMESTAMP_EN
      stamp[0]    <= '0;
      stamp[1]    <= '0;
      out_stamp   <= '0;
`endif
    end else begin
      bank_full <= (bank_full | close_vec) & ~free_vec;

      if (is_run) begin
        if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`ifdef CONSOLE_TIMESTAMP_EN
        if ((store || lf_close) && cap_cnt == '0) stamp[cap_bank] <= cycle_count;
`endif
        if (close) begin
          bank_len[cap_bank] <= cnt_next;
          cap_bank           <= ~cap_bank;
          cap_cnt            <= '0;
        end else if (store) begin
          cap_cnt <= cnt_next;
        end
        if (go_done) begin
          exit_code <= sim_exit_code;
          run_state <= S_FLUSH_DONE;
        end else if (go_to) begin
          run_state <= S_FLUSH_TO;
        end else if (cycle_count != '1) begin
          cycle_count <= cycle_count + 1'b1;
        end
      end else if (bank_full == 2'b00 && !out_valid) begin
        if (run_state == S_FLUSH_DONE) begin
          run_state <= S_DONE;
          done      <= 1'b1;
        end else if (run_state == S_FLUSH_TO) begin
          run_state <= S_TIMEOUT;
          timeout   <= 1'b1;
        end
      end

      if (take) begin
        if (mid) begin
          rd_idx <= nidx;
          if (nidx < bank_len[rd_bank]) begin
            out_data <= mem[rd_bank][nidx];
            out_last <= 1'b0;
          end else begin
            out_data <= LF;
            out_last <= 1'b1;
          end
        end else begin
          if (out_valid) rd_bank <= ~rd_bank;
          if (bank_full[nb] || close_vec[nb]) begin
            out_valid <= 1'b1;
            rd_idx    <= '0;
            out_last  <= (nlen == '0);
            out_data  <= (nlen == '0) ? LF : first_byte;
`ifdef CONSOLE_TIMESTAMP_EN
            out_stamp <= bypass ? cycle_count : stamp[nb];
`endif
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'h00;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_console_monitor.sv
`default_nettype none
// ============================================================================
// tb_sim_console_monitor: directed bench for sim_console_monitor. Rev 1.0
// ============================================================================
module tb_sim_console_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_sim_done, a_out_ready, a_out_valid, a_out_last, a_done, a_timeout;
  logic [7:0]  a_in_data, a_out_data;
  logic [31:0] a_sim_exit_code, a_exit_code, a_cycle_count;
  logic [15:0] a_drop_count;

  logic        b_in_valid, b_sim_done, b_out_ready, b_out_valid, b_out_last, b_done, b_timeout;
  logic [7:0]  b_in_data, b_out_data;
  logic [31:0] b_sim_exit_code, b_exit_code, b_cycle_count;
  logic [15:0] b_drop_count;
`ifdef CONSOLE_TIMESTAMP_EN
  logic [31:0] a_out_stamp, b_out_stamp;
`endif

  int total = 0;
  int bad   = 0;

  sim_console_monitor #(.LINE_MAX(8), .TIMEOUT_CYCLES(0), .CNT_W(32), .DROP_CR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .sim_done(a_sim_done), .sim_exit_code(a_sim_exit_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .done(a_done), .timeout(a_timeout), .exit_code(a_exit_code),
    .drop_count(a_drop_count), .cycle_count(a_cycle_count)
`ifdef CONSOLE_TIMESTAMP_EN
    , .out_stamp(a_out_stamp)
`endif
  );

  sim_console_monitor #(.LINE_MAX(16), .TIMEOUT_CYCLES(100), .CNT_W(32), .DROP_CR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .sim_done(b_sim_done), .sim_exit_code(b_sim_exit_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .done(b_done), .timeout(b_timeout), .exit_code(b_exit_code),
    .drop_count(b_drop_count), .cycle_count(b_cycle_count)
`ifdef CONSOLE_TIMESTAMP_EN
    , .out_stamp(b_out_stamp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; one byte per call, back-to-back capable.
  task automatic a_send(input logic [7:0] b);
    a_in_valid = 1'b1;
    a_in_data  = b;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] b);
    b_in_valid = 1'b1;
    b_in_data  = b;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  // Wait (bounded) for a beat with ready high, check it, then step past its acceptance.
  task automatic beat(input bit sel, input string tag, input logic [7:0] d, input logic l);
    int n = 0;
    while (!(sel ? b_out_valid : a_out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(sel ? b_out_valid : a_out_valid), 32'd1);
    chk({tag, " data"},  32'(sel ? b_out_data  : a_out_data),  32'(d));
    chk({tag, " last"},  32'(sel ? b_out_last  : a_out_last),  32'(l));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] digits [10];
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_sim_done = 0; a_sim_exit_code = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = 0; b_sim_done = 0; b_sim_exit_code = 0; b_out_ready = 1;
    for (int i = 0; i < 10; i++) digits[i] = 8'(8'h30 + i);

    repeat (3) @(negedge clk);
    chk("rst out_valid", 32'(a_out_valid), 32'd0);
    chk("rst drop",      32'(a_drop_count), 32'd0);
    chk("rst cycles",    a_cycle_count, 32'd0);
    chk("rst exit",      a_exit_code, 32'd0);
    chk("rst done",      32'(a_done), 32'd0);
    rst_n = 1'b1;

    // CR kept as a character when DROP_CR=0
    b_send(8'h41); b_send(8'h0D); b_send(8'h0A);
    beat(1, "crkeep0", 8'h41, 1'b0);
    beat(1, "crkeep1", 8'h0D, 1'b0);
    beat(1, "crkeep2", 8'h0A, 1'b1);
    chk("b early timeout", 32'(b_timeout), 32'd0);

    // watchdog: TIMEOUT_CYCLES=100
    for (int n = 0; n < 300 && !b_timeout; n++) @(negedge clk);
    chk("b timeout",      32'(b_timeout), 32'd1);
    chk("b frozen count", b_cycle_count, 32'd99);
    chk("b done",         32'(b_done), 32'd0);

    // "Hi\n" and out_valid rise timing
    a_send(8'h48); a_send(8'h69);
    chk("hi pre", 32'(a_out_valid), 32'd0);
    a_send(8'h0A);
    chk("hi rise", 32'(a_out_valid), 32'd1);
    beat(0, "hi0", 8'h48, 1'b0);
    beat(0, "hi1", 8'h69, 1'b0);
    beat(0, "hi2", 8'h0A, 1'b1);
    chk("hi idle", 32'(a_out_valid), 32'd0);

    // CR dropped when DROP_CR=1
    a_send(8'h41); a_send(8'h0D); a_send(8'h0A);
    beat(0, "crdrop0", 8'h41, 1'b0);
    beat(0, "crdrop1", 8'h0A, 1'b1);

    // truncation at LINE_MAX=8
    for (int i = 0; i < 10; i++) a_send(digits[i]);
    a_send(8'h0A);
    for (int i = 0; i < 7; i++) beat(0, "trunc", digits[i], 1'b0);
    beat(0, "trunc lf", 8'h0A, 1'b1);
    chk("trunc drop", 32'(a_drop_count), 32'd3);

    // backpressure: both banks fill, third line dropped
    a_out_ready = 1'b0;
    a_send(8'h61); a_send(8'h0A); a_send(8'h62); a_send(8'h0A); a_send(8'h63); a_send(8'h0A);
    chk("bp drop", 32'(a_drop_count), 32'd5);
    repeat (4) @(negedge clk);
    chk("bp hold valid", 32'(a_out_valid), 32'd1);
    chk("bp hold data",  32'(a_out_data), 32'h61);
    chk("bp hold last",  32'(a_out_last), 32'd0);
    a_out_ready = 1'b1;
    beat(0, "bp a", 8'h61, 1'b0);
    beat(0, "bp alf", 8'h0A, 1'b1);
    beat(0, "bp b", 8'h62, 1'b0);
    beat(0, "bp blf", 8'h0A, 1'b1);
    chk("bp idle", 32'(a_out_valid), 32'd0);

    // TIMEOUT_CYCLES=0 never fires
    repeat (10000) @(negedge clk);
    chk("no timeout", 32'(a_timeout), 32'd0);

    // partial line flushed by sim_done
    a_send(8'h6F); a_send(8'h6B);
    a_sim_done = 1'b1; a_sim_exit_code = 32'h0000002A;
    @(negedge clk);
    a_sim_done = 1'b0; a_sim_exit_code = 32'h0;
    beat(0, "fl o", 8'h6F, 1'b0);
    beat(0, "fl k", 8'h6B, 1'b0);
    beat(0, "fl lf", 8'h0A, 1'b1);
    for (int n = 0; n < 20 && !a_done; n++) @(negedge clk);
    chk("done",      32'(a_done), 32'd1);
    chk("exit code", a_exit_code, 32'h2A);
    chk("done to",   32'(a_timeout), 32'd0);
    a_send(8'h7A); a_send(8'h0A);
    repeat (5) @(negedge clk);
    chk("post ignore valid", 32'(a_out_valid), 32'd0);
    chk("post ignore drop",  32'(a_drop_count), 32'd5);

    // reset mid-drain drops out_valid at once
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b0;
    a_send(8'h78); a_send(8'h0A);
    chk("pre rst valid", 32'(a_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async rst valid", 32'(a_out_valid), 32'd0);
    chk("async rst done", 32'(a_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("lost after rst", 32'(a_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
